scp_run_ctrl: RTL and testbench
===============================

Name: scp_run_ctrl

Overview:
- Run controller for the single-cycle processor.
- Loads a program into instruction memory through a valid/ready word stream, then holds the core in reset, releases it, and gates its clock enable.
- Stops the core on a halt instruction (ECALL) or when a cycle budget is used up. Supports single-step debug.
- Sits between the top-level test/host interface and the processor core and its IMEM write port.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words; sets the load-overflow limit.
- ADDR_W, 8, IMEM word-address width; must satisfy 2**ADDR_W >= IMEM_DEPTH.
- MAX_CYCLES, 1024, run-cycle budget before a forced stop; must be >= 1.
- HALT_INSN, 32'h00000073, instruction encoding treated as halt (ECALL).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse; begins LOAD from IDLE or DONE.
- load_valid  input  1  a load word is present.
- load_data  input  32  instruction word.
- load_last  input  1  marks the final word; qualified by load_valid.
- load_ready  output  1  controller accepts a word this cycle.
- imem_we  output  1  IMEM write strobe.
- imem_waddr  output  ADDR_W  IMEM write word address.
- imem_wdata  output  32  IMEM write data.
- core_reset  output  1  active-high reset to the processor core.
- core_en  output  1  core advances one instruction in a cycle where this is 1.
- instr  input  32  instruction the core is executing this cycle.
- step_mode  input  1  1 = single-step; sampled on entry to RUN.
- step_req  input  1  one-cycle pulse; advances one instruction in step mode.
- cycle_count  output  32  number of enabled core cycles in the current run.
- state  output  2  00 IDLE, 01 LOAD, 10 RUN, 11 DONE.
- done  output  1  high in DONE.
- halt_cause  output  2  00 none, 01 halt instruction, 10 cycle budget, 11 load overflow.

Behaviour:
- Reset (reset==0 at a clk edge), regardless of current state:
  - state=IDLE; load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - core_reset=1, core_en=0, cycle_count=0, done=0, halt_cause=00.
  - A reset in the middle of LOAD or RUN aborts it. The partial IMEM contents are not cleared.
- IDLE:
  - core_reset=1, load_ready=0.
  - start -> LOAD next cycle. Entering LOAD sets the write pointer=0, cycle_count=0, halt_cause=00.
- LOAD:
  - load_ready=1 while in LOAD.
  - A handshake (load_valid & load_ready) writes the word the same cycle: imem_we=1, imem_waddr=ptr, imem_wdata=load_data. Then ptr increments.
  - Handshake with load_last=1 -> RUN next cycle.
  - Handshake while ptr==IMEM_DEPTH-1 and load_last=0 -> the word is written, then DONE with halt_cause=11 (overflow). ptr never wraps.
  - start is ignored in LOAD.
- RUN:
  - First RUN cycle: core_reset=1, core_en=0. This is the release cycle; step_mode is latched here.
  - From the second cycle on: core_reset=0.
  - Free-run: core_en=1 every cycle.
  - Step mode: core_en=1 only in a cycle where step_req=1. A step_req that arrives during the release cycle is dropped.
  - cycle_count increments on every cycle with core_en=1.
  - Halt check happens only in a cycle with core_en=1 and core_reset=0:
    - if instr==HALT_INSN: that cycle still counts, then DONE, halt_cause=01;
    - else if cycle_count+1==MAX_CYCLES: DONE, halt_cause=10.
    - If both conditions hold in the same cycle, the halt instruction wins (01).
  - cycle_count saturates at 32'hFFFFFFFF.
  - start is ignored in RUN.
- DONE:
  - core_en=0, core_reset=0 (core state is held for inspection), done=1.
  - cycle_count and halt_cause hold their values.
  - start -> LOAD, clearing done, cycle_count and halt_cause.
- Output timing:
  - All outputs are registered, except load_ready, imem_we, imem_waddr, imem_wdata and core_en. Those are combinational from state and inputs so a write or step takes effect in the same cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> state=00, core_reset=1, core_en=0, cycle_count=0, done=0.
- Load and run:
  - Stimulus: start; stream 4 words (addi ×3, then 32'h00000073) with load_last on word 4, load_valid held high.
  - Required: imem writes at addresses 0..3 on consecutive cycles, then the release cycle, then 4 core_en cycles.
  - Result: done=1, halt_cause=01, cycle_count=4.
- Cycle budget:
  - Stimulus: MAX_CYCLES=34, run a program with no ECALL (instr=32'h00000013 constant).
  - Required: exactly 34 core_en pulses, then done=1, halt_cause=10, cycle_count=34.
- Load overflow and backpressure:
  - Stimulus: IMEM_DEPTH=8; stream 9 words with no load_last; insert a load_valid=0 gap at word 3.
  - Required: no write during the gap; 8 writes at addresses 0..7; then DONE with halt_cause=11; load_ready=0 afterwards.
- Single step:
  - Stimulus: step_mode=1; 3 step_req pulses spaced 5 cycles apart; instr=HALT on the 3rd.
  - Required: core_en high only on those 3 cycles; done after the 3rd; cycle_count=3.
- Reset mid-run:
  - Stimulus: reset=0 during RUN at cycle_count=10.
  - Required: next state IDLE, cycle_count=0, core_reset=1.
  - Then: a new start reloads and runs normally.

Source files
------------

// File: rtl/scp_run_ctrl.sv
// Run controller: streams a program into IMEM, releases the core from reset,
// gates its clock enable and stops it on ECALL, cycle budget or load overflow.
module scp_run_ctrl #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter int          MAX_CYCLES = 1024,
    parameter logic [31:0] HALT_INSN  = 32'h00000073
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              core_en,
    input  logic [31:0]       instr,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [31:0]       cycle_count,
    output logic [1:0]        state,
    output logic              done,
    output logic [1:0]        halt_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [32:0]       BUDGET    = 33'(MAX_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              done_q, done_d;
    logic              core_rst_q, core_rst_d;
    logic              step_q, step_d;
    logic              hs;
    logic              releasing;
    logic              run_en;
    logic [32:0]       cnt_inc;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        step_d     = step_q;
        load_ready = reset && (state_q == S_LOAD);
        hs         = load_ready && load_valid;
        imem_we    = hs;
        imem_waddr = hs ? ptr_q : '0;
        imem_wdata = hs ? load_data : '0;
        // the first RUN cycle still holds the core in reset
        releasing  = (state_q == S_RUN) && core_rst_q;
        run_en     = reset && (state_q == S_RUN) && !core_rst_q
                     && (!step_q || step_req);
        core_en    = run_en;
        cnt_inc    = {1'b0, cnt_q} + 33'd1;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    cause_d = 2'b00;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (load_last) begin
                        state_d = S_RUN;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        cause_d = 2'b11;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (releasing) begin
                    step_d = step_mode;
                end
                if (run_en) begin
                    if (cnt_q != 32'hFFFF_FFFF) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (instr == HALT_INSN) begin
                        state_d = S_DONE;
                        cause_d = 2'b01;
                    end else if (cnt_inc == BUDGET) begin
                        state_d = S_DONE;
                        cause_d = 2'b10;
                    end
                end
            end
            default: ;
        endcase

        done_d     = (state_d == S_DONE);
        // core leaves reset one cycle after RUN is entered and stays out in DONE
        core_rst_d = !((state_d == S_DONE)
                       || ((state_d == S_RUN) && (state_q == S_RUN)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            cause_q    <= 2'b00;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            step_q     <= step_d;
        end
    end

    assign cycle_count = cnt_q;
    assign state       = state_q;
    assign done        = done_q;
    assign halt_cause  = cause_q;
    assign core_reset  = core_rst_q;

endmodule

// File: tb/tb_scp_run_ctrl.sv
// Scoreboard bench for scp_run_ctrl: stimulus pushes expected IMEM writes and
// run outcomes; a monitor thread pops and compares them as the DUT shows them.
module tb_scp_run_ctrl;

    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam int          MAXC  = 34;
    localparam logic [31:0] HALT  = 32'h00000073;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          core_en;
    logic [31:0]   instr;
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic [31:0]   cycle_count;
    logic [1:0]    state;
    logic          done;
    logic [1:0]    halt_cause;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    typedef struct {
        logic [1:0]  c;
        logic [31:0] n;
    } res_t;

    wr_t         wq[$];
    res_t        rq[$];
    logic [31:0] iprog[0:63];
    logic [31:0] ldata[0:15];
    int          en_seen = 0;
    int          base = 0;
    bit          step_active = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign instr = iprog[6'(en_seen - base)];

    scp_run_ctrl #(
        .IMEM_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .MAX_CYCLES(MAXC),
        .HALT_INSN (HALT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .core_en    (core_en),
        .instr      (instr),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .cycle_count(cycle_count),
        .state      (state),
        .done       (done),
        .halt_cause (halt_cause)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected outcome of a free run whose first ECALL sits at index hp
    function automatic res_t run_result(input int hp);
        res_t r;
        if (hp < MAXC) begin
            r.c = 2'b01;
            r.n = 32'(hp + 1);
        end else begin
            r.c = 2'b10;
            r.n = 32'(MAXC);
        end
        return r;
    endfunction

    task automatic counter();
        forever begin
            @(posedge clk);
            if (core_en) en_seen <= en_seen + 1;
        end
    endtask

    task automatic monitor();
        logic dprev = 1'b0;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                if (wq.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    w = wq.pop_front();
                    chk("waddr", 32'(imem_waddr), 32'(w.a));
                    chk("wdata", imem_wdata, w.d);
                end
            end
            if (core_en && step_active && !step_req) flag("step_gate");
            if (done && !dprev) begin
                if (rq.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    r = rq.pop_front();
                    chk("halt_cause", 32'(halt_cause), 32'(r.c));
                    chk("cycle_count", cycle_count, r.n);
                    chk("en_pulses", 32'(en_seen - base), r.n);
                    chk("done_core_reset", 32'(core_reset), 32'd0);
                end
            end
            dprev = done;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        base = en_seen;
        chk("start_state", 32'(state), 32'd1);
        chk("start_clear", {cycle_count[29:0], halt_cause}, 32'd0);
        chk("start_done", 32'(done), 32'd0);
    endtask

    task automatic load_words(input int n, input bit last, input int gap_at,
                              input bit rgap);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at || (rgap && $urandom_range(0, 3) == 0)) begin
                load_valid = 1'b0;
                tick();
                tick();
            end
            load_valid = 1'b1;
            load_data  = ldata[i];
            load_last  = last && (i == n - 1);
            if (i < DEPTH) wq.push_back('{a: AW'(i), d: ldata[i]});
            ok = 1'b0;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                if (load_ready) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            chk("load_accept", 32'(ok), 32'(i < DEPTH));
            if (!ok) break;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic free_run(input int nw, input int hp);
        for (int i = 0; i < 64; i++) iprog[i] = {$urandom_range(0, 32'h1FF_FFFF), 7'h13};
        if (hp < 64) iprog[hp] = HALT;
        for (int i = 0; i < nw; i++) ldata[i] = $urandom;
        rq.push_back(run_result(hp));
        do_start();
        load_words(nw, 1'b1, -1, 1'b1);
        wait_done();
    endtask

    initial begin
        fork
            counter();
            monitor();
        join_none
        for (int i = 0; i < 64; i++) iprog[i] = NOP;

        // reset held two cycles
        tick();
        tick();
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_core_reset", 32'(core_reset), 32'd1);

        // load 3 addi + ECALL, run to halt
        ldata[0] = 32'h00100093;
        ldata[1] = 32'h00208113;
        ldata[2] = 32'h00310193;
        ldata[3] = HALT;
        for (int i = 0; i < 4; i++) iprog[i] = ldata[i];
        rq.push_back('{c: 2'b01, n: 32'd4});
        do_start();
        load_words(4, 1'b1, -1, 1'b0);
        chk("release_state", 32'(state), 32'd2);
        chk("release_core_reset", 32'(core_reset), 32'd1);
        chk("release_core_en", 32'(core_en), 32'd0);
        tick();
        chk("run_core_reset", 32'(core_reset), 32'd0);
        wait_done();

        // cycle budget, and halt colliding with the last budget cycle
        free_run(3, 100);
        free_run(2, MAXC - 1);
        free_run(1, MAXC);

        // overflow with a backpressure gap at word 3
        for (int i = 0; i < 9; i++) ldata[i] = $urandom;
        rq.push_back('{c: 2'b11, n: 32'd0});
        do_start();
        load_words(9, 1'b0, 3, 1'b0);
        tick();
        tick();
        chk("ovf_load_ready", 32'(load_ready), 32'd0);
        chk("ovf_state", 32'(state), 32'd3);
        chk("ovf_done", 32'(done), 32'd1);

        // single step: a step during release is dropped, then 3 steps
        for (int i = 0; i < 64; i++) iprog[i] = NOP;
        iprog[2] = HALT;
        for (int i = 0; i < 3; i++) ldata[i] = iprog[i];
        step_mode = 1'b1;
        rq.push_back('{c: 2'b01, n: 32'd3});
        do_start();
        load_words(3, 1'b1, -1, 1'b0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        step_active = 1'b1;
        chk("step_dropped", 32'(en_seen - base), 32'd0);
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 4; t++) tick();
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
        end
        wait_done();
        step_active = 1'b0;
        step_mode = 1'b0;

        // reset in the middle of a run
        for (int i = 0; i < 64; i++) iprog[i] = NOP;
        ldata[0] = NOP;
        do_start();
        load_words(1, 1'b1, -1, 1'b0);
        begin
            bit hit = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (cycle_count == 32'd10) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reach_count10", 32'(hit), 32'd1);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_count", cycle_count, 32'd0);
        chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();

        // randomized free runs after the abort
        for (int k = 0; k < 6; k++) begin
            free_run($urandom_range(1, DEPTH), $urandom_range(0, 45));
        end

        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("results_drained", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
